// File: rtl/fakeram_1rw_mask.sv
// Generic single-port SRAM model: bit-masked writes, RD_LATENCY-deep read pipe, post-reset zero fill.
// Optional FAKERAM_X_CORRUPT_EN: X/Z on we_in/addr_in during an access poisons the whole array (sim only).
module fakeram_1rw_mask #(
   parameter int BITS       = 32,
   parameter int WORD_DEPTH = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce_in,
   input  logic                  we_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [BITS-1:0]       wd_in,
   input  logic [BITS-1:0]       w_mask_in,
   output logic [BITS-1:0]       rd_out,
   output logic                  rd_valid,
   output logic                  init_busy
);
   typedef enum logic {ST_INIT, ST_READY} state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(WORD_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic [BITS-1:0]       mem [WORD_DEPTH];

   logic                  accept;
   logic                  in_range;
   logic                  x_hit;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [BITS-1:0]       mem_word;
   logic [BITS-1:0]       mem_wdata;
   logic [BITS-1:0]       rd_word;

   logic                  vld_q [RD_LATENCY];
   logic                  vld_d [RD_LATENCY];
   logic [BITS-1:0]       dat_q [RD_LATENCY];
   logic [BITS-1:0]       dat_d [RD_LATENCY];

   assign accept   = (state_q == ST_READY) && ce_in;
   assign in_range = {1'b0, addr_in} < DEPTH_W;
   assign mem_word = mem[addr_in];

`ifdef FAKERAM_X_CORRUPT_EN
   assign x_hit = accept && ($isunknown(we_in) || $isunknown(addr_in));
`else
   assign x_hit = 1'b0;
`endif

   // Out-of-range reads complete normally but return zero.
   always_comb begin
      rd_word = in_range ? mem_word : '0;
`ifdef FAKERAM_X_CORRUPT_EN
      if (x_hit) rd_word = 'x;
`endif
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      mem_we     = 1'b0;
      mem_waddr  = addr_in;
      mem_wdata  = (mem_word & ~w_mask_in) | (wd_in & w_mask_in);
      case (state_q)
         ST_INIT: begin
            mem_we     = 1'b1;
            mem_waddr  = init_cnt_q;
            mem_wdata  = '0;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
               state_d    = ST_READY;
               init_cnt_d = '0;
            end
         end
         ST_READY: begin
            mem_we = ce_in && we_in && in_range && !x_hit;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // Array has no reset; the INIT sweep clears it instead.
   always_ff @(posedge clk) begin
`ifdef FAKERAM_X_CORRUPT_EN
      if (x_hit) begin
         $display("WARNING: %m: X/Z on we_in=%b addr_in=%b, memory corrupted", we_in, addr_in);
         for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= 'x;
      end else
`endif
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Stage 0 captures the read-first word; the last stage only loads on a valid so rd_out holds.
   always_comb begin
      vld_d[0] = accept;
      dat_d[0] = accept ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
      if (!vld_d[RD_LATENCY-1]) dat_d[RD_LATENCY-1] = dat_q[RD_LATENCY-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_d[i];
            dat_q[i] <= dat_d[i];
         end
      end
   end

   assign rd_valid  = vld_q[RD_LATENCY-1];
   assign rd_out    = dat_q[RD_LATENCY-1];
   assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_fakeram_1rw_mask.sv
// Bench for fakeram_1rw_mask: directed plus random accesses against a word-array reference and a
// due-cycle read scoreboard; uses a 48-word array so addresses 48..63 are out of range.
module tb_fakeram_1rw_mask;
   localparam int BITS  = 32;
   localparam int DEPTH = 48;
   localparam int AW    = 6;
   localparam int LAT   = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ce_in = 1'b0;
   logic            we_in = 1'b0;
   logic [AW-1:0]   addr_in = '0;
   logic [BITS-1:0] wd_in = '0;
   logic [BITS-1:0] w_mask_in = '0;
   logic [BITS-1:0] rd_out;
   logic            rd_valid;
   logic            init_busy;

   fakeram_1rw_mask #(
      .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ce_in(ce_in), .we_in(we_in), .addr_in(addr_in),
      .wd_in(wd_in), .w_mask_in(w_mask_in), .rd_out(rd_out), .rd_valid(rd_valid),
      .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              due;
      logic [BITS-1:0] data;
   } rd_t;

   rd_t             pend[$];
   logic [BITS-1:0] ref_mem [DEPTH];
   logic [BITS-1:0] last_rd;
   int              init_left;
   int              cyc;
   int              errors;
   int              checks;

   task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic            exp_v;
      logic [BITS-1:0] exp_d;
      exp_v = 1'b0;
      exp_d = last_rd;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_v   = 1'b1;
         exp_d   = pend[0].data;
         last_rd = exp_d;
         void'(pend.pop_front());
      end
      chk({tag, "/valid"}, BITS'(rd_valid), BITS'(exp_v));
      chk({tag, "/data"}, rd_out, exp_d);
      chk({tag, "/busy"}, BITS'(init_busy), BITS'(init_left > 0));
   endtask

   task automatic step(input logic ce, input logic we, input logic [AW-1:0] a,
                       input logic [BITS-1:0] wd, input logic [BITS-1:0] m, input string tag);
      logic [BITS-1:0] rv;
      ce_in = ce; we_in = we; addr_in = a; wd_in = wd; w_mask_in = m;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         if (init_left > 0) begin
            init_left--;
         end else if (ce) begin
            rv = (int'(a) < DEPTH) ? ref_mem[a] : '0;
            pend.push_back('{due: cyc + LAT - 1, data: rv});
            if (we && int'(a) < DEPTH)
               for (int b = 0; b < BITS; b++) if (m[b]) ref_mem[a][b] = wd[b];
         end
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, tag);
   endtask

   task automatic rand_step(input string tag);
      step(1'($urandom), 1'($urandom), AW'($urandom), $urandom, $urandom, tag);
   endtask

   task automatic assert_reset(input string tag);
      rst_n = 1'b0;
      pend.delete();
      last_rd   = '0;
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      #1;
      check_outputs(tag);
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0; last_rd = '0; init_left = DEPTH;
      #2;
      assert_reset("por");
      for (int i = 0; i < 2; i++) rand_step("in_reset");
      rst_n = 1'b1;

      // INIT: random traffic must be ignored for exactly DEPTH edges
      for (int i = 0; i < DEPTH; i++) rand_step("init");

      for (int a = 0; a < 64; a++) step(1'b1, 1'b0, AW'(a), '0, '0, "zero_rd");
      idle(LAT, "flush");

      step(1'b1, 1'b1, 6'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mask_w1");
      step(1'b1, 1'b1, 6'd5, 32'h0000_0000, 32'h0000_FF00, "mask_w2");
      step(1'b1, 1'b0, 6'd5, '0, '0, "mask_rd");
      idle(LAT, "flush");
      chk("mask_word", rd_out, 32'hFFFF_00FF);

      step(1'b1, 1'b1, 6'd1, 32'h11, 32'hFFFF_FFFF, "burst_w");
      step(1'b1, 1'b1, 6'd2, 32'h22, 32'hFFFF_FFFF, "burst_w");
      step(1'b1, 1'b1, 6'd3, 32'h33, 32'hFFFF_FFFF, "burst_w");
      idle(LAT, "flush");
      for (int a = 1; a <= 3; a++) step(1'b1, 1'b0, AW'(a), '0, '0, "burst_rd");
      idle(LAT, "burst_out");
      chk("burst_last", rd_out, 32'h33);

      step(1'b1, 1'b1, 6'd7, 32'hA, 32'hFFFF_FFFF, "rf_wa");
      step(1'b1, 1'b1, 6'd7, 32'hB, 32'hFFFF_FFFF, "rf_wb");
      idle(LAT, "flush");
      chk("read_first", rd_out, 32'hA);
      step(1'b1, 1'b0, 6'd7, '0, '0, "rf_rd");
      idle(LAT, "flush");
      chk("read_after_w", rd_out, 32'hB);

      step(1'b1, 1'b1, 6'd50, 32'h5, 32'hFFFF_FFFF, "oor_w");
      step(1'b1, 1'b0, 6'd50, '0, '0, "oor_rd");
      idle(LAT, "flush");
      chk("oor_zero", rd_out, 32'h0);
      step(1'b1, 1'b0, 6'd2, '0, '0, "alias_rd");
      idle(LAT, "flush");
      chk("alias_keep", rd_out, 32'h22);

      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(3) != 0), 1'($urandom), AW'($urandom), $urandom, $urandom, "rand");
      end
      idle(LAT, "flush");

      // reset with two reads still in the pipe
      step(1'b1, 1'b0, 6'd3, '0, '0, "mid_rd");
      step(1'b1, 1'b0, 6'd5, '0, '0, "mid_rd");
      assert_reset("mid_rst");
      for (int i = 0; i < 2; i++) rand_step("in_reset2");
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) rand_step("reinit");
      step(1'b1, 1'b0, 6'd5, '0, '0, "post_rd");
      step(1'b1, 1'b0, 6'd2, '0, '0, "post_rd");
      step(1'b1, 1'b0, 6'd7, '0, '0, "post_rd");
      idle(LAT, "flush");
      chk("post_rst_zero", rd_out, 32'h0);

`ifdef FAKERAM_X_CORRUPT_EN
      ce_in = 1'b1; we_in = 1'b0; addr_in = 'x;
      @(posedge clk);
      ce_in = 1'b0; addr_in = '0;
      repeat (LAT) @(posedge clk);
      ce_in = 1'b1; addr_in = 6'd1;
      @(posedge clk);
      ce_in = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("x_valid", BITS'(rd_valid), BITS'(1'b1));
      chk("x_data", BITS'($isunknown(rd_out)), BITS'(1'b1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
